rmst_mem_reader: RTL and testbench

- Read-master engine that sits on the far side of the rmst_* control/user interface used by the tile loaders (in_fm, weight, out_fm loads).
- Accepts a go/base/length command, issues pipelined burst-free reads on an Avalon-style memory port, and buffers returned words in a show-ahead FIFO.
- The tile loader drains the FIFO through user_read_buffer / user_buffer_data / user_data_available.
- Synthesizable; also used as the memory-side model in laptop_sim.

---
 rtl/rmst_mem_reader_pkg.sv | 23 ++
 rtl/rmst_fifo.sv | 53 +++++
 rtl/rmst_mem_reader.sv | 120 ++++++++++++
 tb/tb_rmst_mem_reader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rmst_mem_reader_pkg.sv
// Shared definitions for the rmst read-master: sequencer state encoding and
// word-size helpers used to derive bytes-per-word and its shift amount.
package rmst_mem_reader_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rmst_state_e;

  function automatic int rmst_bpw(input int xdw);
    return xdw / 8;
  endfunction

  function automatic int rmst_log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rmst_fifo.sv
// Synchronous show-ahead FIFO: head word is presented combinationally and
// forced to zero while empty so the consumer never sees stale storage.
module rmst_fifo #(
  parameter int DW    = 128,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic [AW:0]   o_used,
  output logic          o_empty,
  output logic          o_full
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_used;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_used == '0);
  assign o_full  = (r_used == (AW+1)'(DEPTH));
  assign o_used  = r_used;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_used <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + (AW+1)'(1);
        2'b01:   r_used <= r_used - (AW+1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

endmodule

// File: rtl/rmst_mem_reader.sv
// Read-master engine: latches a go/base/length command, issues credit-limited
// pipelined reads and buffers returned words in a show-ahead FIFO.
module rmst_mem_reader
  import rmst_mem_reader_pkg::*;
#(
  parameter int XAW        = 32,
  parameter int XDW        = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           control_fixed_location,
  input  logic [XAW-1:0] control_read_base,
  input  logic [XAW-1:0] control_read_length,
  input  logic           control_go,
  output logic           control_done,
  input  logic           user_read_buffer,
  output logic [XDW-1:0] user_buffer_data,
  output logic           user_data_available,
  output logic           mem_read,
  output logic [XAW-1:0] mem_address,
  input  logic           mem_waitrequest,
  input  logic [XDW-1:0] mem_readdata,
  input  logic           mem_readdatavalid
);

  localparam int BPW = rmst_bpw(XDW);
  localparam int BPW_LG = rmst_log2(BPW);
  localparam logic [XAW-1:0] ADDR_STEP = XAW'(BPW);

  rmst_state_e      r_state;
  logic [XAW-1:0]   r_addr;
  logic [XAW-1:0]   r_words_left;
  logic             r_fixed;
  logic             r_done;
  logic [FIFO_AW:0] r_outstanding;

  logic [FIFO_AW:0]   w_used;
  logic               w_empty;
  logic               w_full;
  logic [FIFO_AW+1:0] w_inflight;
  logic               w_credit;
  logic               w_read;
  logic               w_accept;
  logic               w_return;
  logic [XAW-1:0]     w_go_words;

  // Words already buffered plus words still in flight must fit the FIFO, so a
  // return can always be pushed no matter how late it arrives.
  assign w_inflight = {1'b0, w_used} + {1'b0, r_outstanding};
  assign w_credit   = !w_full && (w_inflight < (FIFO_AW+2)'(FIFO_DEPTH));
  assign w_read     = (r_state == ST_RUN) && (r_words_left != '0) && w_credit;
  assign w_accept   = w_read && !mem_waitrequest;
  assign w_return   = mem_readdatavalid && (r_outstanding != '0);
  assign w_go_words = control_read_length >> BPW_LG;

  assign mem_read            = w_read;
  assign mem_address         = r_addr;
  assign control_done        = r_done;
  assign user_data_available = !w_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_words_left  <= '0;
      r_fixed       <= 1'b0;
      r_done        <= 1'b1;
      r_outstanding <= '0;
    end else begin
      if (w_accept && !w_return)
        r_outstanding <= r_outstanding + (FIFO_AW+1)'(1);
      else if (!w_accept && w_return)
        r_outstanding <= r_outstanding - (FIFO_AW+1)'(1);

      case (r_state)
        ST_IDLE: begin
          if (control_go) begin
            r_addr       <= control_read_base;
            r_words_left <= w_go_words;
            r_fixed      <= control_fixed_location;
            if (w_go_words != '0) begin
              r_state <= ST_RUN;
              r_done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            r_words_left <= r_words_left - XAW'(1);
            if (!r_fixed) r_addr <= r_addr + ADDR_STEP;
          end
          if ((r_words_left == '0) && (r_outstanding == '0)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rmst_fifo #(
    .DW    (XDW),
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_return),
    .i_data  (mem_readdata),
    .i_pop   (user_read_buffer),
    .o_data  (user_buffer_data),
    .o_used  (w_used),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

endmodule

// File: tb/tb_rmst_mem_reader.sv
// Directed bench for rmst_mem_reader: latency-3 memory model, ordered
// consumer and hand-computed address/word expectations.
module tb_rmst_mem_reader;

  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         control_fixed_location = 1'b0;
  logic [31:0]  control_read_base = '0;
  logic [31:0]  control_read_length = '0;
  logic         control_go = 1'b0;
  logic         control_done;
  logic         user_read_buffer = 1'b0;
  logic [127:0] user_buffer_data;
  logic         user_data_available;
  logic         mem_read;
  logic [31:0]  mem_address;
  logic         mem_waitrequest = 1'b0;
  logic [127:0] mem_readdata = '0;
  logic         mem_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  rmst_mem_reader dut (
    .clk                    (clk),
    .rst                    (rst),
    .control_fixed_location (control_fixed_location),
    .control_read_base      (control_read_base),
    .control_read_length    (control_read_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_read_buffer       (user_read_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_data_available    (user_data_available),
    .mem_read               (mem_read),
    .mem_address            (mem_address),
    .mem_waitrequest        (mem_waitrequest),
    .mem_readdata           (mem_readdata),
    .mem_readdatavalid      (mem_readdatavalid)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] word(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a, ~a, a + 32'h1234_5678};
  endfunction

  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] exp_addr[$];
  logic [31:0] last_addr = '0;
  int cyc = 0;
  int acc_count = 0;
  int ret_count = 0;
  int pop_count = 0;
  int wait_left = 0;
  int pop_mode = 0;
  int pop_credit = 0;
  bit inject = 0;
  bit rd_seen = 0;

  // Memory model: request capture on the active edge.
  always @(posedge clk) begin
    if (!rst) begin
      q_addr.delete();
      q_due.delete();
    end else if (mem_read && !mem_waitrequest) begin
      if (acc_count < exp_addr.size()) chk("req_addr", mem_address, exp_addr[acc_count]);
      else chk("extra_req", acc_count + 1, exp_addr.size());
      q_addr.push_back(mem_address);
      q_due.push_back(cyc + LAT);
      last_addr = mem_address;
      acc_count++;
    end
    if (mem_read) rd_seen = 1;
    cyc++;
  end

  // Memory model: waitrequest and in-order returns, driven on the falling edge.
  always @(negedge clk) begin
    if (wait_left > 0 && acc_count == 1) begin
      mem_waitrequest = 1'b1;
      wait_left--;
      chk("wait_addr", mem_address, 32'h110);
      chk("wait_read", mem_read, 1);
    end else begin
      mem_waitrequest = 1'b0;
    end
    if (inject) begin
      mem_readdatavalid = 1'b1;
      mem_readdata = 128'h0BAD_0BAD_0BAD_0BAD;
      inject = 0;
    end else if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata = word(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
      ret_count++;
    end else begin
      mem_readdatavalid = 1'b0;
    end
  end

  // Consumer: checks each popped word against the expected address order.
  always @(negedge clk) begin
    if (user_data_available && (pop_mode == 1 || pop_credit > 0)) begin
      if (pop_count < exp_addr.size()) chk("rd_data", user_buffer_data, word(exp_addr[pop_count]));
      else chk("extra_word", pop_count + 1, exp_addr.size());
      pop_count++;
      if (pop_credit > 0) pop_credit--;
      user_read_buffer = 1'b1;
    end else begin
      user_read_buffer = 1'b0;
    end
  end

  task automatic setup(input logic [31:0] base, input int n, input bit fixed);
    exp_addr.delete();
    for (int i = 0; i < n; i++) exp_addr.push_back(fixed ? base : base + 32'(i * 16));
    acc_count = 0;
    ret_count = 0;
    pop_count = 0;
    rd_seen = 0;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input bit fixed);
    @(negedge clk);
    control_read_base = base;
    control_read_length = len;
    control_fixed_location = fixed;
    control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k;
    bit early;
    k = 0;
    early = 0;
    while (!(control_done && pop_count == n) && k < budget) begin
      if (control_done && ret_count < n) early = 1;
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, k < budget, 1);
    chk({name, "_early_done"}, early, 0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_done"}, control_done, 1);
    chk({name, "_read"}, mem_read, 0);
    chk({name, "_addr"}, mem_address, 0);
    chk({name, "_avail"}, user_data_available, 0);
    chk({name, "_data"}, user_buffer_data, 0);
  endtask

  typedef struct {
    logic [31:0] base;
    logic [31:0] len;
    bit          fixed;
    int          words;
    logic [31:0] last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{base: 32'h0000_0100, len: 32'd64, fixed: 1'b0, words: 4, last: 32'h0000_0130};
    tbl[1] = '{base: 32'h0000_0040, len: 32'd48, fixed: 1'b1, words: 3, last: 32'h0000_0040};
    tbl[2] = '{base: 32'h0000_0200, len: 32'd40, fixed: 1'b0, words: 2, last: 32'h0000_0210};
    tbl[3] = '{base: 32'hFFFF_FFE0, len: 32'd64, fixed: 1'b0, words: 4, last: 32'h0000_0010};
    tbl[4] = '{base: 32'h0000_0300, len: 32'd0,  fixed: 1'b0, words: 0, last: 32'h0};
    tbl[5] = '{base: 32'h0000_0400, len: 32'd15, fixed: 1'b0, words: 0, last: 32'h0};

    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;

    pop_mode = 1;
    for (int i = 0; i < 6; i++) begin
      setup(tbl[i].base, tbl[i].words, tbl[i].fixed);
      go(tbl[i].base, tbl[i].len, tbl[i].fixed);
      chk("go_lat_read", mem_read, tbl[i].words != 0);
      chk("go_lat_done", control_done, tbl[i].words == 0);
      repeat (2) @(negedge clk);
      wait_done(tbl[i].words, 200, "vec");
      chk("vec_accepts", acc_count, tbl[i].words);
      chk("vec_pops", pop_count, tbl[i].words);
      chk("vec_any_read", rd_seen, tbl[i].words != 0);
      chk("vec_avail_end", user_data_available, 0);
      if (tbl[i].words > 0) chk("vec_last_addr", last_addr, tbl[i].last);
    end

    // Waitrequest held five cycles on the second request.
    setup(32'h100, 4, 0);
    wait_left = 5;
    go(32'h100, 32'd64, 0);
    wait_done(4, 200, "wait");
    chk("wait_accepts", acc_count, 4);
    chk("wait_pops", pop_count, 4);

    // Fixed location with a go pulse during the transfer.
    setup(32'h40, 3, 1);
    go(32'h40, 32'd48, 1);
    @(negedge clk);
    control_read_base = 32'h500;
    control_read_length = 32'd256;
    control_fixed_location = 1'b0;
    control_go = 1'b1;
    @(negedge clk);
    control_go = 1'b0;
    wait_done(3, 200, "fixgo");
    chk("fixgo_accepts", acc_count, 3);
    chk("fixgo_pops", pop_count, 3);

    // Backpressure: consumer holds off, then releases one word at a time.
    pop_mode = 0;
    setup(32'h1000, 64, 0);
    go(32'h1000, 32'd1024, 0);
    repeat (40) @(negedge clk);
    chk("bp_accepts_full", acc_count, 16);
    chk("bp_read_stalled", mem_read, 0);
    chk("bp_avail", user_data_available, 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1 pop_credit = 1;
      repeat (8) @(negedge clk);
      chk("bp_one_pop_one_req", acc_count, 17 + k);
    end
    pop_mode = 1;
    wait_done(64, 1000, "bp");
    chk("bp_accepts", acc_count, 64);
    chk("bp_pops", pop_count, 64);

    // Reset after two of eight words have returned, then a stale return.
    pop_mode = 0;
    setup(32'h800, 8, 0);
    go(32'h800, 32'd128, 0);
    begin
      int k;
      k = 0;
      while (ret_count < 2 && k < 100) begin
        @(negedge clk);
        k++;
      end
      chk("rst_wait_timeout", k < 100, 1);
    end
    @(negedge clk);
    chk("rst_pre_avail", user_data_available, 1);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b1;
    @(posedge clk);
    #1 inject = 1;
    repeat (4) @(negedge clk);
    chk("stale_avail", user_data_available, 0);
    chk("stale_data", user_buffer_data, 0);
    chk("stale_done", control_done, 1);
    chk("stale_read", mem_read, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
